// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the load-and-run controller.
// The state enum lives here so the controller and any tooling agree on it.
package run_ctrl_pkg;

  localparam int CNT_W    = 16;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int LD_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // A zero-length start pulse would never release the processor, so clamp to one cycle.
  function automatic int start_len(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Bundle of the request, preload, memory-write and processor-control signals
// between a host (master) and the run controller (slave).
interface run_ctrl_if;
  import run_ctrl_pkg::*;

  logic                req;
  logic                ld_valid;
  logic                ld_last;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_ready;

  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_dat;

  logic                cpu_start;
  logic                cpu_done;

  logic                busy;
  logic                finished;
  logic                timeout;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [LD_CNT_W-1:0] ld_cnt;

  modport master (
    output req, ld_valid, ld_last, ld_addr, ld_data, cpu_done,
    input  ld_ready, mem_wr_en, mem_addr, mem_dat, cpu_start,
           busy, finished, timeout, cycle_cnt, ld_cnt
  );

  modport slave (
    input  req, ld_valid, ld_last, ld_addr, ld_data, cpu_done,
    output ld_ready, mem_wr_en, mem_addr, mem_dat, cpu_start,
           busy, finished, timeout, cycle_cnt, ld_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Sequences a data-memory preload, a processor start pulse and a supervised run
// that ends in FINISH (processor done) or FAULT (cycle limit reached).
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int MAX_CYC   = 1000,
  parameter int START_CYC = 2
) (
  input  logic     clk,
  input  logic     reset,
  run_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(start_len(START_CYC));
  localparam logic [31:0]      MAX_LIM   = 32'(MAX_CYC);

  state_t           state;
  logic [CNT_W-1:0] start_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic             at_limit;
  logic             restart;
  logic             cnt_en;

  // The limit is judged on the count already shown, so a done in the same
  // cycle can still win and the frozen count never overshoots the limit.
  assign at_limit = (32'(cycle_cnt) >= MAX_LIM);
  assign restart  = bus.req && ((state == S_IDLE) || (state == S_FINISH) || (state == S_FAULT));
  assign cnt_en   = (state == S_RUN) && !bus.cpu_done && !at_limit;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .en    (cnt_en),
    .cnt   (cycle_cnt)
  );

  assign bus.cycle_cnt = cycle_cnt;

  // NOTE: every register here uses <= so all updates in a cycle see the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      start_cnt     <= '0;
      bus.ld_ready  <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_dat   <= '0;
      bus.cpu_start <= 1'b0;
      bus.busy      <= 1'b0;
      bus.finished  <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.ld_cnt    <= '0;
    end else begin
      // NOTE: default the write strobe low each cycle so it is a single-cycle
      // pulse without needing an explicit clear in every branch.
      bus.mem_wr_en <= 1'b0;

      unique case (state)
        S_IDLE, S_FINISH, S_FAULT: begin
          if (bus.req) begin
            state        <= S_LOAD;
            bus.ld_ready <= 1'b1;
            bus.busy     <= 1'b1;
            bus.finished <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.ld_cnt   <= '0;
          end
        end

        S_LOAD: begin
          if (bus.ld_valid && bus.ld_ready) begin
            bus.mem_wr_en <= 1'b1;
            bus.mem_addr  <= bus.ld_addr;
            bus.mem_dat   <= bus.ld_data;
            bus.ld_cnt    <= bus.ld_cnt + 1'b1;
            if (bus.ld_last) begin
              state         <= S_START;
              bus.ld_ready  <= 1'b0;
              bus.cpu_start <= 1'b1;
              start_cnt     <= CNT_W'(1);
            end
          end
        end

        S_START: begin
          if (start_cnt >= START_LIM) begin
            state         <= S_RUN;
            bus.cpu_start <= 1'b0;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (bus.cpu_done) begin
            state        <= S_FINISH;
            bus.busy     <= 1'b0;
            bus.finished <= 1'b1;
          end else if (at_limit) begin
            state       <= S_FAULT;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized bench for run_ctrl: two instances (default limit and a 20-cycle
// limit) share one stimulus stream and are scored against closed-form expectations.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int MAX_A   = 1000;
  localparam int MAX_B   = 20;
  localparam int START_N = 2;

  typedef struct packed {
    logic        busy;
    logic        finished;
    logic        timeout;
    logic        ld_ready;
    logic        cpu_start;
    logic        mem_wr_en;
    logic [15:0] cycle_cnt;
    logic [7:0]  ld_cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, ld_valid, ld_last, cpu_done;
  logic [7:0] ld_addr, ld_data;

  int   n_vec;
  int   n_err;
  obs_t ea, eb;

  logic [7:0] dir_data [3] = '{8'hAA, 8'hBB, 8'hCC};

  always #5 clk = ~clk;

  run_ctrl_if bus_a ();
  run_ctrl_if bus_b ();

  assign bus_a.req = req;           assign bus_b.req = req;
  assign bus_a.ld_valid = ld_valid; assign bus_b.ld_valid = ld_valid;
  assign bus_a.ld_last = ld_last;   assign bus_b.ld_last = ld_last;
  assign bus_a.ld_addr = ld_addr;   assign bus_b.ld_addr = ld_addr;
  assign bus_a.ld_data = ld_data;   assign bus_b.ld_data = ld_data;
  assign bus_a.cpu_done = cpu_done; assign bus_b.cpu_done = cpu_done;

  run_ctrl #(.MAX_CYC(MAX_A), .START_CYC(START_N)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  run_ctrl #(.MAX_CYC(MAX_B), .START_CYC(START_N)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h want=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t get_a();
    return '{busy: bus_a.busy, finished: bus_a.finished, timeout: bus_a.timeout,
             ld_ready: bus_a.ld_ready, cpu_start: bus_a.cpu_start,
             mem_wr_en: bus_a.mem_wr_en, cycle_cnt: bus_a.cycle_cnt, ld_cnt: bus_a.ld_cnt};
  endfunction

  function automatic obs_t get_b();
    return '{busy: bus_b.busy, finished: bus_b.finished, timeout: bus_b.timeout,
             ld_ready: bus_b.ld_ready, cpu_start: bus_b.cpu_start,
             mem_wr_en: bus_b.mem_wr_en, cycle_cnt: bus_b.cycle_cnt, ld_cnt: bus_b.ld_cnt};
  endfunction

  task automatic compare(input string tag);
    check({tag, "/a"}, {2'b00, get_a()}, {2'b00, ea});
    check({tag, "/b"}, {2'b00, get_b()}, {2'b00, eb});
  endtask

  // Last RUN cycle (1-based): the done cycle, or the cycle whose count equals the limit.
  function automatic int last_run(input int done_at, input int max_cyc);
    return (done_at <= max_cyc + 1) ? done_at : max_cyc + 1;
  endfunction

  // Outputs after the edge closing RUN cycle j (j = 0: just entered RUN).
  function automatic obs_t run_exp(input int j, input int done_at, input int max_cyc,
                                   input logic [7:0] lc);
    obs_t e;
    int   lr;
    bit   fin;
    lr          = last_run(done_at, max_cyc);
    fin         = (done_at <= max_cyc + 1);
    e           = '0;
    e.ld_cnt    = lc;
    e.cycle_cnt = 16'((j < lr) ? j : lr - 1);
    e.busy      = (j < lr);
    e.finished  = (j >= lr) && fin;
    e.timeout   = (j >= lr) && !fin;
    return e;
  endfunction

  task automatic clear_inputs();
    req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; cpu_done = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset = 1'b1;
    #1;
    ea = '0;
    eb = '0;
    compare({tag, "_async"});
    check({tag, "_addr"}, {24'b0, bus_a.mem_addr}, 32'h0);
    check({tag, "_dat"}, {24'b0, bus_b.mem_dat}, 32'h0);
    tick();
    reset = 1'b0;
    ld_valid = 1'b1;
    tick();
    clear_inputs();
    compare({tag, "_idle"});
  endtask

  task automatic do_job(input int n_beats, input int done_at, input bit directed,
                        input int abort_load, input int abort_run);
    logic [7:0] a_exp, d_exp, lc;
    int         last_a, last_b, jmax, gap;

    req = 1'b1; ld_valid = 1'($urandom); cpu_done = 1'($urandom);
    tick();
    clear_inputs();
    ea = '0; ea.busy = 1'b1; ea.ld_ready = 1'b1;
    eb = ea;
    compare("req_load");

    for (int i = 0; i < n_beats; i++) begin
      gap = directed ? 1 : ((n_beats > 8) ? 0 : $urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        ld_addr = 8'($urandom); ld_data = 8'($urandom); cpu_done = 1'($urandom);
        tick();
        clear_inputs();
        ea.mem_wr_en = 1'b0; eb = ea;
        compare("load_gap");
      end
      a_exp = directed ? 8'(8'h10 + i) : 8'($urandom);
      d_exp = directed ? dir_data[i] : 8'($urandom);
      ld_valid = 1'b1; ld_addr = a_exp; ld_data = d_exp;
      ld_last  = (i == n_beats - 1);
      req      = ($urandom_range(0, 3) == 0);
      cpu_done = 1'($urandom);
      tick();
      clear_inputs();
      ea.mem_wr_en = 1'b1;
      ea.ld_cnt    = ea.ld_cnt + 8'd1;
      if (i == n_beats - 1) begin
        ea.ld_ready  = 1'b0;
        ea.cpu_start = 1'b1;
      end
      eb = ea;
      compare("load_beat");
      check("mem_addr/a", {24'b0, bus_a.mem_addr}, {24'b0, a_exp});
      check("mem_dat/a", {24'b0, bus_a.mem_dat}, {24'b0, d_exp});
      check("mem_addr/b", {24'b0, bus_b.mem_addr}, {24'b0, a_exp});
      check("mem_dat/b", {24'b0, bus_b.mem_dat}, {24'b0, d_exp});
      if (abort_load == i + 1) begin
        reset_pulse("rst_load");
        return;
      end
    end

    for (int s = 1; s < START_N; s++) begin
      ld_valid = 1'($urandom); ld_last = 1'($urandom);
      cpu_done = 1'($urandom); req = 1'($urandom);
      tick();
      clear_inputs();
      ea.mem_wr_en = 1'b0; eb = ea;
      compare("start");
    end
    ld_valid = 1'($urandom); cpu_done = 1'($urandom);
    tick();
    clear_inputs();
    lc = ea.ld_cnt;
    ea = run_exp(0, done_at, MAX_A, lc);
    eb = run_exp(0, done_at, MAX_B, lc);
    compare("run_enter");

    last_a = last_run(done_at, MAX_A);
    last_b = last_run(done_at, MAX_B);
    jmax   = (last_a > last_b) ? last_a : last_b;
    for (int j = 1; j <= jmax; j++) begin
      cpu_done = (j == done_at);
      ld_valid = 1'($urandom); ld_last = 1'($urandom);
      req      = (j <= last_a && j <= last_b) ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      clear_inputs();
      ea = run_exp(j, done_at, MAX_A, lc);
      eb = run_exp(j, done_at, MAX_B, lc);
      compare("run");
      if (abort_run == j) begin
        reset_pulse("rst_run");
        return;
      end
    end

    for (int h = 0; h < 3; h++) begin
      ld_valid = 1'($urandom); cpu_done = 1'($urandom);
      tick();
      clear_inputs();
      compare("end_hold");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    ld_addr = '0;
    ld_data = '0;
    ea = '0;
    eb = '0;
    #3;
    compare("reset");
    check("reset_addr", {24'b0, bus_a.mem_addr}, 32'h0);
    tick();
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_addr = 8'($urandom); ld_data = 8'($urandom);
      cpu_done = 1'($urandom);
      tick();
      clear_inputs();
      compare("idle_ignore");
    end

    do_job(3, 50, 1'b1, 0, 0);
    do_job(2, 21, 1'b0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      do_job($urandom_range(1, 6), $urandom_range(1, 40), 1'b0, 0, 0);
    end
    do_job(258, 5, 1'b0, 0, 0);
    do_job(4, 10, 1'b0, 2, 0);
    do_job(3, 30, 1'b0, 0, 7);
    do_job(2, 3, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter MAX_CYC, default 1000, is the RUN-state cycle limit before timeout.
REQ-002 Parameter START_CYC, default 2, is the number of cycles cpu_start is held high.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is the asynchronous active-high reset.
REQ-005 Port req, input, 1, requests a new load-and-run sequence.
REQ-006 Ports ld_valid (input, 1), ld_last (input, 1), ld_addr (input, 8) and ld_data (input, 8) carry one preload beat for data memory.
REQ-007 Port ld_ready, output, 1, is high only in LOAD; a beat transfers when ld_valid and ld_ready are both high.
REQ-008 Ports mem_wr_en (output, 1), mem_addr (output, 8) and mem_dat (output, 8) form the write port into data memory.
REQ-009 Port cpu_start, output, 1, drives the processor start input and holds its PC at the start address.
REQ-010 Port cpu_done, input, 1, is the processor done flag.
REQ-011 Ports busy, finished and timeout are 1-bit outputs; cycle_cnt (output, 16) is the RUN cycle count; ld_cnt (output, 8) is the number of beats accepted.

Function
REQ-012 States: IDLE, LOAD, START, RUN, FINISH, FAULT, encoded as a 3-bit enum.
REQ-013 IDLE: req=1 -> LOAD, clearing ld_cnt and cycle_cnt.
REQ-014 LOAD: each transfer registers ld_addr/ld_data onto mem_addr/mem_dat and pulses mem_wr_en for exactly one cycle, the cycle after the transfer; ld_cnt increments.
REQ-015 LOAD: a transfer with ld_last=1 -> START; ld_ready drops the next cycle.
REQ-016 ld_cnt wraps modulo 256; wrap does not end LOAD.
REQ-017 START: cpu_start=1 for exactly START_CYC cycles, then -> RUN with cpu_start=0; START_CYC=0 is treated as 1.
REQ-018 cpu_done is ignored in IDLE, LOAD and START.
REQ-019 RUN: cycle_cnt increments every cycle, saturating at 16'hFFFF.
REQ-020 RUN: cpu_done=1 -> FINISH, and cycle_cnt freezes at the value of that cycle, excluding the increment.
REQ-021 RUN: cycle_cnt reaching MAX_CYC with cpu_done=0 -> FAULT; if cpu_done=1 in the same cycle, FINISH wins.
REQ-022 FINISH asserts finished=1, and FAULT asserts timeout=1; both outputs are registered and hold while in that state.
REQ-023 FINISH or FAULT with req=1 -> LOAD, clearing finished, timeout and both counters in that transition.
REQ-024 busy=1 exactly in LOAD, START and RUN.
REQ-025 req while busy is ignored.
REQ-026 ld_valid outside LOAD is ignored and produces no mem_wr_en.
REQ-027 All outputs are registered; no combinational path runs from any input to any output.

Reset
REQ-028 reset=1 forces IDLE asynchronously.
REQ-029 During reset, every output is 0, including mem_wr_en, cpu_start, cycle_cnt and ld_cnt.
REQ-030 Reset asserted mid-LOAD or mid-RUN aborts without a further mem_wr_en pulse.
REQ-031 After reset deasserts, the block waits in IDLE for a fresh req.

Structure
REQ-032 Shared package run_ctrl_pkg holds the state enum, CNT_W=16, ADDR_W=8 and DATA_W=8.
REQ-033 The RUN cycle counter is sub-module sat_counter (width parameter, clear, enable, saturating output).
REQ-034 Everything else is a single FSM plus registers in run_ctrl.

Verification
REQ-035 Bench: req, 3 beats {(0x10,0xAA),(0x11,0xBB),(0x12,0xCC, last)} -> exactly 3 mem_wr_en pulses, each one cycle after its beat, ld_cnt=3, then cpu_start high for 2 cycles.
REQ-036 Bench: cpu_done asserted on the 50th RUN cycle -> finished=1, cycle_cnt=49, busy=0.
REQ-037 Bench: MAX_CYC=20 with no done -> timeout=1 after 20 RUN cycles, cycle_cnt=20; then req -> LOAD with timeout=0.
REQ-038 Bench: MAX_CYC=20 with cpu_done=1 on the cycle cycle_cnt reaches 20 -> FINISH, timeout=0.
REQ-039 Bench: reset pulse mid-LOAD and mid-RUN -> all outputs 0 immediately, state IDLE, no pending write.
REQ-040 Bench: req pulses during RUN, and ld_valid in IDLE -> no state change, no mem_wr_en.
